uart_rx_fifo: RTL
=================

# uart_rx_fifo

Parametrised UART receiver with 16× oversampling, majority-vote bit sampling, false-start rejection, optional parity, 1 or 2 stop bits, and an internal receive FIFO with a valid/ready output port. It replaces the unbuffered receiver beside `uart_baudgen`:
- it drives the x16 baud-enable request;
- it consumes the x16 tick;
- it hands frames, each with its error flags, to the host logic through the FIFO.

## Interface
- `DATA_WIDTH`, 8, data bits per frame, legal range 5–9.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16, FIFO entries, power of two, ≥ 2.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `o_baud_x16_en`  out  1  request to `uart_baudgen` to run the x16 tick generator.
- `i_baud_x16`  in  1  one-cycle pulse at 16× baud rate.
- `i_RX`  in  1  asynchronous serial line; idle level is high.
- `o_dout`  out  DATA_WIDTH  head-of-FIFO data.
- `o_error`  out  2  head-of-FIFO flags: bit 1 framing error, bit 0 parity error.
- `o_valid`  out  1  FIFO non-empty; `o_dout` and `o_error` are valid.
- `i_ready`  in  1  consumer accepts the head entry when `o_valid & i_ready`.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `o_overrun`  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- `o_break`  out  1  one-cycle pulse on break detection; tied 0 without the break macro.

## Operation
- `i_RX` passes through a 2-flop synchroniser, reset value 1. All logic uses the synchronised value `rx_s`.
- State machine states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE
  - `o_baud_x16_en` = 0.
  - A falling edge of `rx_s` moves to START, clears the 4-bit tick counter and sets `o_baud_x16_en` = 1.
- Tick counter
  - Counts `i_baud_x16` pulses 0..15 per bit cell and wraps to 0.
  - The bit sample is the majority of `rx_s` captured at ticks 7, 8 and 9, evaluated on tick 9.
- START
  - Majority 1: false start, return to IDLE.
  - Majority 0: go to DATA when the counter wraps.
- DATA
  - `DATA_WIDTH` cells, shifted in LSB first.
  - Then go to PARITY if `PARITY`≠0, otherwise to STOP.
- PARITY
  - Even mode: parity error = XOR of data and parity bit ≠ 0.
  - Odd mode: parity error = XOR of data and parity bit ≠ 1.
- STOP
  - Framing error is set if any stop-bit sample is 0.
  - The frame completes on tick 9 of the last stop cell. The state returns to IDLE the next cycle, mid-cell, so the receiver resynchronises on the next falling edge.
- On completion the entry {error, data} is pushed to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and `o_overrun` pulses.
- FIFO
  - Synchronous, registered outputs, first-in first-out.
  - A pop occurs when `o_valid & i_ready`.
  - Push and pop in the same cycle when full: both happen, no overrun, `o_level` unchanged.
  - Pop when empty is ignored.
- Reset (asserted at any time, including mid-frame or mid-transfer):
  - state IDLE, FIFO emptied, synchroniser set to 1.
  - All outputs 0: `o_dout`, `o_error`, `o_valid`, `o_level`, `o_overrun`, `o_break`, `o_baud_x16_en`.
- `o_dout` and `o_error` hold their last value while `o_valid` = 0.

## Timing
- `i_RX` falling edge to START: 3 cycles (2 synchroniser cycles + 1 edge-detect register).
- Completion (tick 9 of last stop cell) to FIFO write: 1 cycle. Write to `o_valid` = 1 on an empty FIFO: 1 cycle.
- `o_level` updates the cycle after each push or pop.
- `o_overrun` and `o_break` are asserted for exactly 1 cycle.
- `o_baud_x16_en` is high from the cycle START is entered until the cycle IDLE is re-entered.

## Configuration
- Macro: `UART_RX_BREAK_DET_EN`.
- Defined:
  - A break is a frame whose data, parity (if present) and stop samples are all 0.
  - A break pulses `o_break`, pushes nothing, and enters BREAK_WAIT.
  - BREAK_WAIT returns to IDLE only after `rx_s` = 1.
- Not defined:
  - No BREAK_WAIT logic; `o_break` = 0.
  - A break is pushed as data 0 with `o_error` = 2'b10.

## Test plan
Clock 25 MHz, 115200 baud, x16 divisor 13 with fractional adjust 6; reference `uart_tx` drives `i_RX` unless stated otherwise.
- Send 0xA6, then 0x37, 0x00 and 0xFF, with `PARITY`=0 and `i_ready`=1 → four entries in order, each with `o_error`=00; `o_valid` pulses once per frame.
- `PARITY`=1, bit-level driver sends 0x37 with parity bit 0 (correct bit is 1) → entry 0x37, `o_error`=01. Repeat with `PARITY`=2 and parity bit 0 → `o_error`=00.
- Bit-level driver sends 0x55 with stop bit 0, then line high → entry 0x55, `o_error`=10; next frame 0x5A is received clean.
- `i_RX` low for 4 x16 ticks, then high → no push; `o_baud_x16_en` drops within 12 ticks of the edge. A following frame 0xC3 is received correctly.
- `FIFO_DEPTH`=4, `i_ready`=0, send 5 frames → `o_level`=4 and `o_overrun` pulses once. Draining yields the first 4 frames in order. Then, with the FIFO full, assert `i_ready` in the completion cycle of a frame → no overrun, `o_level` stays 4.
- Line held low for 2 frame times, then high.
  - Macro on: one `o_break` pulse, `o_level` stays 0.
  - Macro off: one entry 0x00 with `o_error`=10.
  - Either way, the next frame 0x81 is received clean.
- Assert `i_rst` for 1 cycle mid-DATA with 2 entries queued → all outputs 0 the next cycle; a following frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Receive-FIFO output port of uart_rx_fifo, presented as a valid/ready
//   stream plus an occupancy count.
//   master : the receiver side (drives data, flags, valid and level)
//   slave  : the consumer side (drives ready)
//   o_dout   head-of-FIFO data
//   o_error  head-of-FIFO flags, bit 1 framing error, bit 0 parity error
//   o_valid  FIFO non-empty
//   i_ready  consumer takes the head entry when o_valid & i_ready
//   o_level  current FIFO occupancy
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_WIDTH-1:0]         o_dout;
    logic [1:0]                    o_error;
    logic                          o_valid;
    logic                          i_ready;
    logic [$clog2(FIFO_DEPTH):0]   o_level;

    modport master (output o_dout, o_error, o_valid, o_level, input i_ready);
    modport slave  (input o_dout, o_error, o_valid, o_level, output i_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with 16x oversampling, 3-sample majority vote per bit,
//   false-start rejection, optional parity, 1 or 2 stop bits, feeding a
//   synchronous receive FIFO with registered outputs.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   o_baud_x16_en  request to the baud generator to run the x16 tick
//   i_baud_x16     one-cycle x16 tick
//   i_RX           asynchronous serial line, idle high
//   rx_if          FIFO output stream (uart_rx_fifo_if.master)
//   o_overrun      1-cycle pulse: completed frame dropped, FIFO full
//   o_break        1-cycle pulse on break detection (0 without the macro)
//
// Configuration
//   UART_RX_BREAK_DET_EN  when defined, an all-zero frame (data, parity,
//   stop) is reported on o_break instead of being queued, and the receiver
//   waits for the line to return high before re-arming.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_baud_x16_en,
    input  logic               i_baud_x16,
    input  logic               i_RX,
    uart_rx_fifo_if.master     rx_if,
    output logic               o_overrun,
    output logic               o_break
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [3:0] BIT_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic       ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_t;

    // ---------------------------------------------------------------
    // Line synchroniser and falling-edge detect
    // ---------------------------------------------------------------
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic fall;

    assign fall = rx_prev_q & ~rx_s_q;

    // ---------------------------------------------------------------
    // Receiver state
    // ---------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic                   s7_q, s7_d, s8_q, s8_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   push_q, push_d;
    logic [EW-1:0]          push_ent_q, push_ent_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                   zero_q, zero_d;
    logic                   brk_q, brk_d;
`endif

    logic at9, wrap, maj;

    assign at9  = i_baud_x16 && (tick_q == 4'd9);
    assign wrap = i_baud_x16 && (tick_q == 4'd15);
    // Samples at ticks 7 and 8 are held; tick 9 uses the live value.
    assign maj  = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);

    assign o_baud_x16_en = (state_q != S_IDLE);

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push_d     = 1'b0;
        push_ent_d = push_ent_q;
`ifdef UART_RX_BREAK_DET_EN
        zero_d     = zero_q;
        brk_d      = 1'b0;
`endif
        if (state_q != S_IDLE && i_baud_x16) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == 4'd7) s7_d = rx_s_q;
            if (tick_q == 4'd8) s8_d = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    tick_d     = 4'd0;
                    bit_idx_d  = 4'd0;
                    stop_idx_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d     = 1'b1;
`endif
                end
            end
            S_START: begin
                // A glitch shorter than half a cell votes high: ignore it.
                if (at9 && maj)
                    state_d = S_IDLE;
                else if (wrap)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (at9) begin
                    shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
                    zero_d  = zero_q & ~maj;
`endif
                end
                if (wrap) begin
                    if (bit_idx_q == BIT_LAST)
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (at9) begin
                    perr_d = (^shreg_q) ^ maj ^ ODD_PAR;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d = zero_q & ~maj;
`endif
                end
                if (wrap)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (at9) begin
                    ferr_d = ferr_q | ~maj;
`ifdef UART_RX_BREAK_DET_EN
                    zero_d = zero_q & ~maj;
`endif
                    // Last stop cell completes on its mid-point so the
                    // next start edge can be caught without losing a cell.
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        if (zero_q & ~maj) begin
                            brk_d   = 1'b1;
                            state_d = S_BREAK_WAIT;
                        end else begin
                            push_d     = 1'b1;
                            push_ent_d = {ferr_q | ~maj, perr_q, shreg_q};
                        end
`else
                        push_d     = 1'b1;
                        push_ent_d = {ferr_q | ~maj, perr_q, shreg_q};
`endif
                    end
                end
                if (wrap)
                    stop_idx_d = 1'b1;
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK_WAIT: begin
                if (rx_s_q)
                    state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            tick_q     <= 4'd0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            bit_idx_q  <= 4'd0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            push_q     <= 1'b0;
            push_ent_q <= '0;
        end else begin
            rx_meta_q  <= i_RX;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            push_q     <= push_d;
            push_ent_q <= push_ent_d;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            zero_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            brk_q  <= brk_d;
        end
    end
    assign o_break = brk_q;
`else
    assign o_break = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Receive FIFO
    // ---------------------------------------------------------------
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]  count_q, count_d, remain;
    logic [EW-1:0]  head_q, head_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic           pop, full, push_ok;

    assign pop     = valid_q & rx_if.i_ready;
    assign full    = (count_q == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push_ok = push_q & (~full | pop);
    assign remain  = count_q - LW'(pop);

    always_comb begin
        overrun_d = push_q & full & ~pop;
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        wr_ptr_d  = wr_ptr_q + AW'(push_ok);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
        valid_d = (count_d != '0);
        // Output registers hold their value once the FIFO drains.
        head_d  = head_q;
        if (count_d != '0)
            head_d = (remain == '0) ? push_ent_q : mem_q[rd_ptr_d];
    end

    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_ent_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_if.o_dout  = head_q[DATA_WIDTH-1:0];
    assign rx_if.o_error = head_q[EW-1:DATA_WIDTH];
    assign rx_if.o_valid = valid_q;
    assign rx_if.o_level = count_q;
    assign o_overrun     = overrun_q;

endmodule
